// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: RAM or switch/hex I/O access after WAIT_STATES wait cycles; R pulses WAIT_STATES+1 edges after the request is sampled.
// No backpressure: requests are sampled only in IDLE, and each transaction occupies the block for WAIT_STATES+2 cycles.
module slc3_mem_responder #(
  parameter int          WAIT_STATES = 2,
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_EN,
  input  logic        MEM_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_IN,
  input  logic [15:0] SW,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        ERR,
  output logic        BUSY,
  output logic [15:0] HEX_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    we_q;
  logic [15:0]             addr_q;
  logic [15:0]             data_q;
  logic [15:0]             sw_meta;
  logic [15:0]             sw_sync;
  logic [15:0]             ram [2**ADDR_WIDTH];
  logic                    is_io;
  logic                    in_ram;
  logic [ADDR_WIDTH-1:0]   ram_idx;

  // The I/O address takes priority even if a wider RAM ever overlaps it.
  assign is_io   = (addr_q == IO_ADDR);
  assign in_ram  = ((addr_q >> ADDR_WIDTH) == 16'd0);
  assign ram_idx = addr_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= 16'h0000;
      sw_sync <= 16'h0000;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // No reset on the array: contents survive reset, and an aborted transaction
  // never reaches ACCESS because the async reset forces IDLE first.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && we_q && !is_io && in_ram) begin
      ram[ram_idx] <= data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      MDR_In   <= 16'h0000;
      HEX_OUT  <= 16'h0000;
      R        <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      R   <= 1'b0;
      ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MEM_EN) begin
            we_q     <= MEM_WE;
            addr_q   <= ADDR;
            data_q   <= DATA_IN;
            wait_cnt <= 4'(WAIT_STATES);
            BUSY     <= 1'b1;
            state    <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state <= S_DONE;
          R     <= 1'b1;
          if (is_io) begin
            if (we_q) begin
              HEX_OUT <= data_q;
            end else begin
              MDR_In <= sw_sync;
            end
          end else if (in_ram) begin
            if (!we_q) begin
              MDR_In <= ram[ram_idx];
            end
          end else begin
            ERR <= 1'b1;
            if (!we_q) begin
              MDR_In <= 16'h0000;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/slc3_mem_responder.md
# slc3_mem_responder

Memory-side responder for the SLC-3 datapath. It accepts read and write requests driven from MAR/MDR and services them against an internal word-addressed RAM or a memory-mapped I/O register after a programmable number of wait states. It returns read data on MDR_In with a one-cycle ready pulse. It sits between the datapath and the board I/O (switches, hex display), replacing the fixed-wait-state memory assumption in the control FSM with an explicit handshake.

## Interface
- WAIT_STATES, 2: number of WAIT cycles inserted before the access (0–15 legal).
- ADDR_WIDTH, 10: internal RAM depth is 2^ADDR_WIDTH words of 16 bits.
- IO_ADDR, 16'hFFFF: memory-mapped I/O address (switches on read, hex register on write).
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MEM_EN  in  1  request strobe, level-sampled in IDLE.
- MEM_WE  in  1  1 = write, 0 = read; latched with MEM_EN.
- ADDR  in  16  request address (MAR).
- DATA_IN  in  16  write data (MDR).
- SW  in  16  board switches, asynchronous to clk.
- MDR_In  out  16  read data to the datapath.
- R  out  1  ready; one-cycle pulse at transaction completion.
- ERR  out  1  out-of-range access flag, valid only while R=1.
- BUSY  out  1  high in every state except IDLE.
- HEX_OUT  out  16  hex display register.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE, MEM_EN=1 at an edge:
  - Latch ADDR, MEM_WE and DATA_IN.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT, or straight to ACCESS if WAIT_STATES=0.
- WAIT: decrement the counter each cycle. Go to ACCESS on the edge where the counter equals 1.
- ACCESS: perform the access at the exiting edge, then go to DONE.
  - Latched address == IO_ADDR:
    - Read: MDR_In <= synchronized SW.
    - Write: HEX_OUT <= latched data. RAM is untouched.
  - Latched address < 2^ADDR_WIDTH:
    - Read: MDR_In <= RAM[addr].
    - Write: RAM[addr] <= latched data.
  - Any other address: reads load MDR_In <= 16'h0000, writes are discarded, and ERR is set for the DONE cycle.
- DONE: R=1 and ERR valid. Return to IDLE unconditionally.
- MEM_EN, MEM_WE, ADDR and DATA_IN are ignored outside IDLE, so changes mid-transaction have no effect.
- MEM_EN still high in the first IDLE cycle after DONE starts a new transaction. The requester must drop MEM_EN during the R cycle if it does not want a back-to-back access.
- MDR_In holds its value until the next read completes. Writes never modify MDR_In.
- SW passes through a two-flop synchronizer before use.

## Timing
- Reset (reset=0, async):
  - State goes to IDLE.
  - R=0, ERR=0, BUSY=0, MDR_In=16'h0000, HEX_OUT=16'h0000.
  - Wait counter and synchronizer flops are cleared.
  - RAM contents are not cleared.
- Reset asserted before the ACCESS exit edge aborts the transaction. No RAM or HEX_OUT update occurs and no R pulse follows.
- Latency: with the request sampled at edge e0, R=1 in the cycle after edge e0+WAIT_STATES+1, for exactly one cycle.
  - WAIT_STATES=2: R is high in the 4th cycle counted from the sampling cycle.
  - WAIT_STATES=0: R is high 2 cycles after sampling.
- BUSY rises after e0 and falls after the DONE cycle.
- Minimum request spacing is WAIT_STATES+3 cycles: WAIT_STATES+2 cycles for the transaction plus the IDLE sampling cycle.
- A SW change is visible to reads after at most 2 clk edges of synchronizer delay.

## Test plan
- Reset, then write 16'hBEEF to 16'h0005 with WAIT_STATES=2, then read 16'h0005 -> R pulses once per transaction, exactly 3 edges after each sampling edge; MDR_In=16'hBEEF; ERR=0.
- Set SW=16'h00A5, wait 3 cycles, read 16'hFFFF -> MDR_In=16'h00A5. Write 16'h1234 to 16'hFFFF -> HEX_OUT=16'h1234, RAM[16'h03FF] unchanged.
- Read 16'h0400 with ADDR_WIDTH=10 -> MDR_In=16'h0000 and ERR=1 during R. Write 16'h0400 -> no RAM word changes.
- Hold MEM_EN=1 continuously with reads of 16'h0001 -> back-to-back transactions, R period = WAIT_STATES+3 cycles. Toggle ADDR during WAIT -> the original address is still served.
- Start a write to 16'h0007 (old value 16'h1111), then assert reset during WAIT -> R never pulses, RAM[16'h0007]=16'h1111, all outputs at reset values.
- Re-run with WAIT_STATES=0 -> R high exactly 2 cycles after the sampling edge; data correctness identical to the first scenario.
